bcd_count_scan: RTL and testbench

- 4-digit BCD timer/counter with run control, prescaled count tick and time-multiplexed display scan.
- Sits directly upstream of the BCD-to-7-segment decoder: drives its 4 nibble inputs (a = MSB … d = LSB) and its enable, and one-hot digit-select lines for the shared-segment display.
- One decoder instance is shared by all four digits.

---
 rtl/bcd_count_scan.sv | 346 ++++++++++++++++++++++++++++++++++
 tb/tb_bcd_count_scan.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_scan.sv
// bcd_count_scan: 4-digit BCD timer/counter with start/stop/clear run control,
// a prescaled count tick and a free-running time-multiplexed digit scan that
// feeds a single shared BCD-to-7-segment decoder.
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   defined   - leading zero digits (thousands..tens) are blanked via seg_en;
//               the units digit is always shown.
//   undefined - seg_en is held at 1 and no blanking logic exists.
//
// All state is synchronous to clk; rst is synchronous and active-high.

module bcd_count_scan #(
    parameter int TICK_DIV = 1000000,  // clk cycles per count step (>= 2)
    parameter int SCAN_DIV = 5000      // clk cycles per displayed digit (>= 2)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic        clear,
    input  logic        dir,
    output logic        bcd_a,
    output logic        bcd_b,
    output logic        bcd_c,
    output logic        bcd_d,
    output logic        seg_en,
    output logic [3:0]  dig_sel,
    output logic [15:0] count,
    output logic        running,
    output logic        wrap
);

    // ------------------------------------------------------------------
    // Derived widths and terminal values
    // ------------------------------------------------------------------
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // BCD arithmetic helpers. A digit outside 0..9 can only appear after an
    // upset; it is steered back into the legal range on the next step.
    // ------------------------------------------------------------------
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b1;
                end else if (r[4*i +: 4] > 4'd9) begin
                    r[4*i +: 4] = 4'd9;
                    borrow      = 1'b0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end else begin
                borrow = 1'b0;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Internal signals
    // ------------------------------------------------------------------
    state_t          state_r;
    state_t          state_nxt_s;
    logic            running_nxt_s;

    logic [PW-1:0]   pre_r;
    logic [PW-1:0]   pre_nxt_s;
    logic            tick_s;
    logic            step_s;

    logic [15:0]     count_r;
    logic [15:0]     count_nxt_s;
    logic            wrap_r;
    logic            wrap_nxt_s;
    logic            running_r;

    logic [SW-1:0]   scan_cnt_r;
    logic [1:0]      scan_idx_r;
    logic            scan_last_s;

    logic [3:0]      dig_sel_r;
    logic [3:0]      dig_sel_s;
    logic [3:0]      nib_r;
    logic [3:0]      nib_s;
    logic            seg_en_r;
    logic            seg_en_s;

    // ------------------------------------------------------------------
    // Run-control FSM
    // ------------------------------------------------------------------

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: clear beats stop beats start
    always_comb begin
        state_nxt_s = state_r;
        if (clear) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state_nxt_s = ST_PAUSE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_nxt_s = ST_RUN;
                    end else begin
                        state_nxt_s = ST_PAUSE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM outputs: running mirrors the state being entered so the register
    // that carries it is coincident with state_r
    always_comb begin
        running_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_RUN:   running_nxt_s = 1'b1;
            ST_IDLE:  running_nxt_s = 1'b0;
            ST_PAUSE: running_nxt_s = 1'b0;
            default:  running_nxt_s = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Prescaler and count datapath
    // ------------------------------------------------------------------

    // Tick generation and qualified count step
    always_comb begin
        tick_s = (state_r == ST_RUN) && (pre_r == PRE_LAST);
        step_s = tick_s && !clear && !stop;
    end

    // Prescaler next value: advances in RUN (including the stop cycle so a
    // resume finishes the partial period), holds in PAUSE, zero in IDLE
    always_comb begin
        pre_nxt_s = pre_r;
        if (clear) begin
            pre_nxt_s = '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (pre_r == PRE_LAST) begin
                        pre_nxt_s = '0;
                    end else begin
                        pre_nxt_s = pre_r + PW'(1);
                    end
                end
                ST_PAUSE: pre_nxt_s = pre_r;
                ST_IDLE:  pre_nxt_s = '0;
                default:  pre_nxt_s = '0;
            endcase
        end
    end

    // Count next value and roll-over detection
    always_comb begin
        count_nxt_s = count_r;
        wrap_nxt_s  = 1'b0;
        if (clear) begin
            count_nxt_s = 16'h0000;
            wrap_nxt_s  = 1'b0;
        end else if (step_s) begin
            if (dir) begin
                count_nxt_s = bcd_inc(count_r);
                wrap_nxt_s  = (count_r == 16'h9999);
            end else begin
                count_nxt_s = bcd_dec(count_r);
                wrap_nxt_s  = (count_r == 16'h0000);
            end
        end else begin
            count_nxt_s = count_r;
            wrap_nxt_s  = 1'b0;
        end
    end

    // Count, prescaler and status registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r     <= '0;
            count_r   <= 16'h0000;
            wrap_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            pre_r     <= pre_nxt_s;
            count_r   <= count_nxt_s;
            wrap_r    <= wrap_nxt_s;
            running_r <= running_nxt_s;
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------

    // Scan terminal-count detect
    always_comb begin
        scan_last_s = (scan_cnt_r == SCAN_LAST);
    end

    // Free-running scan counter and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt_r <= '0;
            scan_idx_r <= 2'd0;
        end else begin
            if (scan_last_s) begin
                scan_cnt_r <= '0;
                scan_idx_r <= scan_idx_r + 2'd1;
            end else begin
                scan_cnt_r <= scan_cnt_r + SW'(1);
                scan_idx_r <= scan_idx_r;
            end
        end
    end

    // Select the nibble, digit strobe and blanking for the current index
    always_comb begin
        nib_s     = 4'd0;
        dig_sel_s = 4'b0001;
        seg_en_s  = 1'b1;
        case (scan_idx_r)
            2'd0: begin
                nib_s     = count_r[3:0];
                dig_sel_s = 4'b0001;
            end
            2'd1: begin
                nib_s     = count_r[7:4];
                dig_sel_s = 4'b0010;
            end
            2'd2: begin
                nib_s     = count_r[11:8];
                dig_sel_s = 4'b0100;
            end
            2'd3: begin
                nib_s     = count_r[15:12];
                dig_sel_s = 4'b1000;
            end
            default: begin
                nib_s     = count_r[3:0];
                dig_sel_s = 4'b0001;
            end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        // A digit is lit if it or any more-significant digit is non-zero
        case (scan_idx_r)
            2'd0:    seg_en_s = 1'b1;
            2'd1:    seg_en_s = |count_r[15:4];
            2'd2:    seg_en_s = |count_r[15:8];
            2'd3:    seg_en_s = |count_r[15:12];
            default: seg_en_s = 1'b1;
        endcase
`else
        seg_en_s = 1'b1;
`endif
    end

    // Display output registers: strobe, nibble and enable change together
    always_ff @(posedge clk) begin
        if (rst) begin
            dig_sel_r <= 4'b0001;
            nib_r     <= 4'd0;
            seg_en_r  <= 1'b1;
        end else begin
            dig_sel_r <= dig_sel_s;
            nib_r     <= nib_s;
            seg_en_r  <= seg_en_s;
        end
    end

    // ------------------------------------------------------------------
    // Output ports
    // ------------------------------------------------------------------
    assign bcd_a   = nib_r[3];
    assign bcd_b   = nib_r[2];
    assign bcd_c   = nib_r[1];
    assign bcd_d   = nib_r[0];
    assign seg_en  = seg_en_r;
    assign dig_sel = dig_sel_r;
    assign count   = count_r;
    assign running = running_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_bcd_count_scan.sv
// Self-checking bench for bcd_count_scan (TICK_DIV=4, SCAN_DIV=2).
// A decimal-integer model predicts every output each cycle; directed
// sequences add hand-computed expectations; a random phase exercises
// coinciding control pulses and a mid-run reset.

module tb_bcd_count_scan;

    localparam int TD = 4;
    localparam int SD = 2;

    logic        clk = 1'b0;
    logic        rst, start, stop, clear, dir;
    logic        bcd_a, bcd_b, bcd_c, bcd_d, seg_en, running, wrap;
    logic [3:0]  dig_sel;
    logic [15:0] count;

    int errors = 0;
    int checks = 0;

    bcd_count_scan #(.TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear),
        .dir(dir), .bcd_a(bcd_a), .bcd_b(bcd_b), .bcd_c(bcd_c),
        .bcd_d(bcd_d), .seg_en(seg_en), .dig_sel(dig_sel), .count(count),
        .running(running), .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pow10(input int i);
        int p = 1;
        for (int k = 0; k < i; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        for (int k = 0; k < 4; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
        return r;
    endfunction

    // ---------------- behavioural model ----------------
    bit         m_valid = 1'b0;
    int         m_val, m_mode, m_phase, m_n, m_pidx;   // mode: 0 idle, 1 run, 2 pause
    bit         m_wrap, m_tick;
    logic [3:0] e_dig, e_nib, one4;
    bit         e_seg;

    always begin
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b1; m_val = 0; m_mode = 0; m_phase = 0; m_n = 0;
            m_wrap = 1'b0; e_dig = 4'b0001; e_nib = 4'd0; e_seg = 1'b1;
        end else if (m_valid) begin
            m_pidx = (m_n / SD) % 4;
            one4   = 4'b0001;
            e_dig  = one4 << m_pidx;
            e_nib  = 4'((m_val / pow10(m_pidx)) % 10);
`ifdef LEADING_ZERO_BLANK_EN
            e_seg  = (m_pidx == 0) || ((m_val / pow10(m_pidx)) != 0);
`else
            e_seg  = 1'b1;
`endif
            m_n++;
            m_tick = (m_mode == 1) && (m_phase == TD - 1);
            m_wrap = 1'b0;
            if (clear) begin
                m_val = 0; m_phase = 0; m_mode = 0;
            end else if (m_mode == 0) begin
                if (start) m_mode = 1;
            end else if (m_mode == 1) begin
                m_phase = (m_phase + 1) % TD;
                if (stop) m_mode = 2;
                else if (m_tick) begin
                    if (dir) begin
                        m_wrap = (m_val == 9999);
                        m_val  = (m_val + 1) % 10000;
                    end else begin
                        m_wrap = (m_val == 0);
                        m_val  = (m_val + 9999) % 10000;
                    end
                end
            end else begin
                if (start) m_mode = 1;
            end
        end
        @(negedge clk);
        if (m_valid) begin
            check("m_count",   32'(count),   32'(to_bcd(m_val)));
            check("m_running", 32'(running), 32'(m_mode == 1));
            check("m_wrap",    32'(wrap),    32'(m_wrap));
            check("m_dig_sel", 32'(dig_sel), 32'(e_dig));
            check("m_nibble",  32'({bcd_a, bcd_b, bcd_c, bcd_d}), 32'(e_nib));
            check("m_seg_en",  32'(seg_en),  32'(e_seg));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(); start = 1'b1; cyc(); start = 1'b0; endtask
    task automatic pulse_stop();  stop  = 1'b1; cyc(); stop  = 1'b0; endtask
    task automatic pulse_clear(); clear = 1'b1; cyc(); clear = 1'b0; endtask

    task automatic wait_change(input string name);
        logic [15:0] old;
        bit seen;
        old = count; seen = 1'b0;
        for (int i = 0; i < 4 * TD && !seen; i++) begin
            cyc();
            if (count !== old) seen = 1'b1;
        end
        check({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_until(input logic [15:0] v, input int budget, input string name);
        bit seen;
        seen = (count === v);
        for (int i = 0; i < budget && !seen; i++) begin
            cyc();
            if (count === v) seen = 1'b1;
        end
        check({name, "_timeout"}, 32'(seen), 32'd1);
    endtask

    function automatic logic [3:0] nib_for(input logic [3:0] sel, input logic [15:0] v);
        case (sel)
            4'b0001: return v[3:0];
            4'b0010: return v[7:4];
            4'b0100: return v[11:8];
            4'b1000: return v[15:12];
            default: return 4'hF;
        endcase
    endfunction

    // ---------------- directed + random stimulus ----------------
    initial begin
        int seen_cnt [4];
        logic [3:0] exp_seg;
        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; dir = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        check("rst_count",   32'(count),   32'h0000);
        check("rst_dig_sel", 32'(dig_sel), 32'h1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_wrap",    32'(wrap),    32'd0);

        // start, first two ticks
        pulse_start();
        check("start_running", 32'(running), 32'd1);
        cyc(); cyc(); cyc();
        check("pre_tick_count", 32'(count), 32'h0000);
        cyc();
        check("tick1_count", 32'(count), 32'h0001);
        repeat (4) cyc();
        check("tick2_count", 32'(count), 32'h0002);

        // decimal carries
        wait_until(16'h0009, 100, "to_0009");
        wait_change("c10");
        check("carry_tens", 32'(count), 32'h0010);
        wait_until(16'h0099, 500, "to_0099");
        wait_change("c100");
        check("carry_hund", 32'(count), 32'h0100);
        check("no_wrap",    32'(wrap),  32'd0);

        // clear + start together: clear wins
        clear = 1'b1; start = 1'b1; cyc(); clear = 1'b0; start = 1'b0;
        check("clr_start_count",   32'(count),   32'h0000);
        check("clr_start_running", 32'(running), 32'd0);

        // down-count wrap and borrow
        dir = 1'b0;
        pulse_start();
        wait_change("dn_wrap");
        check("dn_wrap_count", 32'(count), 32'h9999);
        check("dn_wrap_pulse", 32'(wrap),  32'd1);
        cyc();
        check("dn_wrap_clear", 32'(wrap),  32'd0);
        wait_until(16'h9990, 100, "to_9990");
        wait_change("borrow");
        check("borrow_count", 32'(count), 32'h9989);

        // up-count wrap
        dir = 1'b1;
        wait_until(16'h9999, 100, "to_9999");
        wait_change("up_wrap");
        check("up_wrap_count", 32'(count), 32'h0000);
        check("up_wrap_pulse", 32'(wrap),  32'd1);

        // stop 2 cycles after a tick, resume finishes partial period
        wait_change("pre_stop");
        check("pre_stop_count", 32'(count), 32'h0001);
        cyc();
        pulse_stop();
        check("stop_running", 32'(running), 32'd0);
        repeat (20) cyc();
        check("frozen_count", 32'(count), 32'h0001);
        pulse_start();
        check("resume_running", 32'(running), 32'd1);
        cyc();
        check("resume_early", 32'(count), 32'h0001);
        cyc();
        check("resume_tick", 32'(count), 32'h0002);

        // scan with 1234
        pulse_clear();
        pulse_start();
        wait_until(16'h1234, 6000, "to_1234");
        pulse_stop();
        cyc();
        for (int k = 0; k < 4; k++) seen_cnt[k] = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("scan_nibble", 32'({bcd_a, bcd_b, bcd_c, bcd_d}), 32'(nib_for(dig_sel, 16'h1234)));
            for (int k = 0; k < 4; k++) if (dig_sel == (4'b0001 << k)) seen_cnt[k]++;
        end
        for (int k = 0; k < 4; k++) check("scan_hold", 32'(seen_cnt[k]), 32'd2);

        // leading-zero blanking at 0042 and 0000
        pulse_clear();
        pulse_start();
        wait_until(16'h0042, 400, "to_0042");
        pulse_stop();
        cyc();
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = 4'b0011;
`else
        exp_seg = 4'b1111;
`endif
        for (int i = 0; i < 8; i++) begin
            cyc();
            for (int k = 0; k < 4; k++)
                if (dig_sel == (4'b0001 << k)) check("blank_0042", 32'(seg_en), 32'(exp_seg[k]));
        end
        pulse_clear();
        cyc();
`ifdef LEADING_ZERO_BLANK_EN
        exp_seg = 4'b0001;
`else
        exp_seg = 4'b1111;
`endif
        for (int i = 0; i < 8; i++) begin
            cyc();
            for (int k = 0; k < 4; k++)
                if (dig_sel == (4'b0001 << k)) check("blank_0000", 32'(seg_en), 32'(exp_seg[k]));
        end

        // random control pulses with one mid-run reset
        for (int i = 0; i < 3000; i++) begin
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            clear = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 63) == 0) dir = ~dir;
            rst   = (i == 1500);
            cyc();
            if (i == 1500) begin
                check("mid_rst_count",   32'(count),   32'h0000);
                check("mid_rst_running", 32'(running), 32'd0);
                check("mid_rst_dig_sel", 32'(dig_sel), 32'h1);
            end
        end
        rst = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        cyc(); cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // absolute time limit
    initial begin
        #5000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "timeout");
    end

endmodule
